// File: rtl/tb_cmd_responder.sv
// Command responder for the test sequencer. It decodes and executes fixed-width SET, WAIT
// (rise/fall), CHECK and WAIT_CYCLES commands, then returns a one-cycle acknowledge with status.
module tb_cmd_responder #(
    parameter int unsigned SET_SIZE    = 5,
    parameter int unsigned SET_WIDTH   = 32,
    parameter int unsigned WAIT_SIZE   = 5,
    parameter int unsigned CHECK_SIZE  = 5,
    parameter int unsigned CHECK_WIDTH = 32,
    parameter int unsigned ERR_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_cmd_valid,
    input  logic [2:0]                        i_cmd_op,
    input  logic [7:0]                        i_cmd_sel,
    input  logic [31:0]                       i_cmd_data,
    input  logic [31:0]                       i_cmd_timeout,
    output logic                              o_cmd_ack,
    output logic [1:0]                        o_cmd_status,
    output logic                              o_busy,
    output logic [SET_SIZE*SET_WIDTH-1:0]     o_set,
    input  logic [WAIT_SIZE-1:0]              i_wait,
    input  logic [CHECK_SIZE*CHECK_WIDTH-1:0] i_check,
    output logic [ERR_WIDTH-1:0]              o_err_cnt,
    output logic                              o_overrun
);

    localparam logic [2:0] OpNop       = 3'd0;
    localparam logic [2:0] OpSet       = 3'd1;
    localparam logic [2:0] OpWaitRise  = 3'd2;
    localparam logic [2:0] OpWaitFall  = 3'd3;
    localparam logic [2:0] OpCheck     = 3'd4;
    localparam logic [2:0] OpWaitCyc   = 3'd5;

    localparam logic [1:0] StatOk      = 2'd0;
    localparam logic [1:0] StatChkFail = 2'd1;
    localparam logic [1:0] StatTimeout = 2'd2;
    localparam logic [1:0] StatBadCmd  = 2'd3;

    typedef enum logic [1:0] {StIdle, StWaitEv, StDelay, StAck} state_e;

    state_e                          state_q, state_d;
    logic                            fall_q, fall_d;
    logic [7:0]                      sel_q, sel_d;
    logic [31:0]                     cnt_q, cnt_d;
    logic                            to_en_q, to_en_d;
    logic [WAIT_SIZE-1:0]            wait_q;
    logic [SET_SIZE*SET_WIDTH-1:0]   set_q, set_d;
    logic [1:0]                      status_q, status_d;
    logic [ERR_WIDTH-1:0]            err_q, err_d;
    logic                            overrun_q, overrun_d;

    logic                            ev_cur, ev_hist, ev_hit;
    logic [CHECK_WIDTH-1:0]          chk_val;
    logic                            enter_ack;
    logic [1:0]                      new_status;

    // Select the watched wait bit and its history by the latched channel.
    always_comb begin
        ev_cur  = 1'b0;
        ev_hist = 1'b0;
        for (int unsigned k = 0; k < WAIT_SIZE; k++) begin
            if (sel_q == 8'(k)) begin
                ev_cur  = i_wait[k];
                ev_hist = wait_q[k];
            end
        end
        ev_hit = fall_q ? (!ev_cur && ev_hist) : (ev_cur && !ev_hist);
    end

    always_comb begin
        chk_val = '0;
        for (int unsigned k = 0; k < CHECK_SIZE; k++) begin
            if (i_cmd_sel == 8'(k)) begin
                chk_val = i_check[k*CHECK_WIDTH +: CHECK_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        fall_d     = fall_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        to_en_d    = to_en_q;
        set_d      = set_q;
        status_d   = status_q;
        err_d      = err_q;
        overrun_d  = overrun_q;
        enter_ack  = 1'b0;
        new_status = StatOk;

        unique case (state_q)
            StIdle: begin
                if (i_cmd_valid) begin
                    sel_d  = i_cmd_sel;
                    fall_d = (i_cmd_op == OpWaitFall);
                    case (i_cmd_op)
                        OpNop: begin
                            enter_ack = 1'b1;
                        end
                        OpSet: begin
                            enter_ack = 1'b1;
                            if ({24'd0, i_cmd_sel} < SET_SIZE) begin
                                for (int unsigned k = 0; k < SET_SIZE; k++) begin
                                    if (i_cmd_sel == 8'(k)) begin
                                        set_d[k*SET_WIDTH +: SET_WIDTH] =
                                            i_cmd_data[SET_WIDTH-1:0];
                                    end
                                end
                            end else begin
                                new_status = StatBadCmd;
                            end
                        end
                        OpWaitRise, OpWaitFall: begin
                            if ({24'd0, i_cmd_sel} < WAIT_SIZE) begin
                                state_d = StWaitEv;
                                cnt_d   = i_cmd_timeout;
                                to_en_d = (i_cmd_timeout != 32'd0);
                            end else begin
                                enter_ack  = 1'b1;
                                new_status = StatBadCmd;
                            end
                        end
                        OpCheck: begin
                            enter_ack = 1'b1;
                            if ({24'd0, i_cmd_sel} >= CHECK_SIZE) begin
                                new_status = StatBadCmd;
                            end else if (chk_val != i_cmd_data[CHECK_WIDTH-1:0]) begin
                                new_status = StatChkFail;
                            end
                        end
                        OpWaitCyc: begin
                            if (i_cmd_data == 32'd0) begin
                                enter_ack = 1'b1;
                            end else begin
                                state_d = StDelay;
                                cnt_d   = i_cmd_data;
                            end
                        end
                        default: begin
                            enter_ack  = 1'b1;
                            new_status = StatBadCmd;
                        end
                    endcase
                end
            end
            StWaitEv: begin
                // An event on the same edge as the final timeout count still reports OK.
                if (ev_hit) begin
                    enter_ack = 1'b1;
                end else if (to_en_q && cnt_q == 32'd1) begin
                    enter_ack  = 1'b1;
                    new_status = StatTimeout;
                end else if (to_en_q) begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StDelay: begin
                if (cnt_q == 32'd1) begin
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (enter_ack) begin
            state_d  = StAck;
            status_d = new_status;
            if (new_status != StatOk && err_q != '1) begin
                err_d = err_q + 1'b1;
            end
        end

        if (i_cmd_valid && state_q != StIdle) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            fall_q    <= 1'b0;
            sel_q     <= '0;
            cnt_q     <= '0;
            to_en_q   <= 1'b0;
            wait_q    <= '0;
            set_q     <= '0;
            status_q  <= StatOk;
            err_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fall_q    <= fall_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            to_en_q   <= to_en_d;
            wait_q    <= i_wait;
            set_q     <= set_d;
            status_q  <= status_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_cmd_ack    = (state_q == StAck);
    assign o_cmd_status = status_q;
    assign o_busy       = (state_q != StIdle);
    assign o_set        = set_q;
    assign o_err_cnt    = err_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_tb_cmd_responder.sv
// Bench for tb_cmd_responder: a vector table of single commands plus hand-written multi-cycle
// sequences; expected acks (status and cycle) are queued at issue and popped when the ack appears.
module tb_tb_cmd_responder;

    logic         clk;
    logic         rst_n;
    logic         i_cmd_valid;
    logic [2:0]   i_cmd_op;
    logic [7:0]   i_cmd_sel;
    logic [31:0]  i_cmd_data;
    logic [31:0]  i_cmd_timeout;
    logic         o_cmd_ack;
    logic [1:0]   o_cmd_status;
    logic         o_busy;
    logic [159:0] o_set;
    logic [4:0]   i_wait;
    logic [159:0] i_check;
    logic [15:0]  o_err_cnt;
    logic         o_overrun;

    tb_cmd_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_cmd_valid   (i_cmd_valid),
        .i_cmd_op      (i_cmd_op),
        .i_cmd_sel     (i_cmd_sel),
        .i_cmd_data    (i_cmd_data),
        .i_cmd_timeout (i_cmd_timeout),
        .o_cmd_ack     (o_cmd_ack),
        .o_cmd_status  (o_cmd_status),
        .o_busy        (o_busy),
        .o_set         (o_set),
        .i_wait        (i_wait),
        .i_check       (i_check),
        .o_err_cnt     (o_err_cnt),
        .o_overrun     (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  sel;
        logic [31:0] data;
        logic [31:0] tmo;
        logic [1:0]  st;
        int          lat;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        int         at;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs [17];
    logic [31:0] exp_set [5];
    int          exp_err;
    int          nchk = 0;
    int          nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle step; any ack seen is matched against the scoreboard head.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst_n && o_cmd_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected ack", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("ack status", 64'(o_cmd_status), 64'(e.st));
                chk("ack cycle", 64'(cyc), 64'(e.at));
                chk("err count", 64'(o_err_cnt), 64'(exp_err));
            end
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] sel, input logic [31:0] data,
                         input logic [31:0] tmo, input logic [1:0] st, input int lat,
                         input bit expect_ack);
        exp_t e;
        i_cmd_valid   = 1'b1;
        i_cmd_op      = op;
        i_cmd_sel     = sel;
        i_cmd_data    = data;
        i_cmd_timeout = tmo;
        if (expect_ack) begin
            e.st = st;
            e.at = cyc + lat;
            sb.push_back(e);
            if (st != 2'd0) exp_err++;
        end
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            chk("ack timed out", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        tick();
    endtask

    task automatic check_sets(input string tag);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("%s set ch%0d", tag, k), 64'(o_set[k*32 +: 32]), 64'(exp_set[k]));
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        i_cmd_valid   = 1'b0;
        i_cmd_op      = 3'd0;
        i_cmd_sel     = 8'd0;
        i_cmd_data    = 32'd0;
        i_cmd_timeout = 32'd0;
        i_wait        = 5'd0;
        for (int k = 0; k < 5; k++) begin
            i_check[k*32 +: 32] = 32'(k) * 32'h111;
            exp_set[k]          = 32'd0;
        end
        i_check[32 +: 32] = 32'h1234;
        exp_err = 0;

        vecs[0]  = '{3'd1, 8'd2,   32'hA5A5_0001, 32'd0,  2'd0, 1};
        vecs[1]  = '{3'd0, 8'd200, 32'd0,         32'd0,  2'd0, 1};
        vecs[2]  = '{3'd4, 8'd1,   32'h1234,      32'd0,  2'd0, 1};
        vecs[3]  = '{3'd4, 8'd1,   32'h1235,      32'd0,  2'd1, 1};
        vecs[4]  = '{3'd5, 8'd0,   32'd5,         32'd0,  2'd0, 6};
        vecs[5]  = '{3'd5, 8'd0,   32'd0,         32'd0,  2'd0, 1};
        vecs[6]  = '{3'd7, 8'd0,   32'd0,         32'd0,  2'd3, 1};
        vecs[7]  = '{3'd1, 8'd5,   32'hFFFF_FFFF, 32'd0,  2'd3, 1};
        vecs[8]  = '{3'd3, 8'd4,   32'd0,         32'd10, 2'd2, 11};
        vecs[9]  = '{3'd2, 8'd5,   32'd0,         32'd0,  2'd3, 1};
        vecs[10] = '{3'd4, 8'd5,   32'd0,         32'd0,  2'd3, 1};
        vecs[11] = '{3'd5, 8'd0,   32'd1,         32'd0,  2'd0, 2};
        vecs[12] = '{3'd1, 8'd0,   32'hDEAD_BEEF, 32'd0,  2'd0, 1};
        vecs[13] = '{3'd2, 8'd3,   32'd0,         32'd1,  2'd2, 2};
        vecs[14] = '{3'd6, 8'd0,   32'd0,         32'd0,  2'd3, 1};
        vecs[15] = '{3'd1, 8'd4,   32'h0000_0004, 32'd0,  2'd0, 1};
        vecs[16] = '{3'd4, 8'd4,   32'h444,       32'd0,  2'd0, 1};

        #12;
        chk("rst ack", 64'(o_cmd_ack), 64'd0);
        chk("rst status", 64'(o_cmd_status), 64'd0);
        chk("rst busy", 64'(o_busy), 64'd0);
        chk("rst err", 64'(o_err_cnt), 64'd0);
        chk("rst overrun", 64'(o_overrun), 64'd0);
        check_sets("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 17; v++) begin
            drive(vecs[v].op, vecs[v].sel, vecs[v].data, vecs[v].tmo, vecs[v].st, vecs[v].lat,
                  1'b1);
            if (vecs[v].op == 3'd1 && vecs[v].st == 2'd0) exp_set[vecs[v].sel] = vecs[v].data;
            wait_done();
            check_sets($sformatf("vec%0d", v));
            chk($sformatf("vec%0d err", v), 64'(o_err_cnt), 64'(exp_err));
            chk($sformatf("vec%0d busy", v), 64'(o_busy), 64'd0);
        end
        chk("overrun clear", 64'(o_overrun), 64'd0);

        // Rise on ch0 sampled at E+7 while ch1 glitches.
        drive(3'd2, 8'd0, 32'd0, 32'd0, 2'd0, 8, 1'b1);
        chk("wait busy", 64'(o_busy), 64'd1);
        i_wait[1] = 1'b1;
        tick();
        i_wait[1] = 1'b0;
        repeat (5) tick();
        i_wait[0] = 1'b1;
        wait_done();
        i_wait[0] = 1'b0;
        tick();

        // Fall on ch4 lands on the tenth wait edge: OK beats timeout.
        i_wait[4] = 1'b1;
        tick();
        drive(3'd3, 8'd4, 32'd0, 32'd10, 2'd0, 11, 1'b1);
        repeat (9) tick();
        i_wait[4] = 1'b0;
        wait_done();
        chk("race err", 64'(o_err_cnt), 64'(exp_err));

        // Command strobe while busy only flags overrun.
        drive(3'd2, 8'd2, 32'd0, 32'd0, 2'd0, 3, 1'b1);
        drive(3'd1, 8'd0, 32'h55, 32'd0, 2'd0, 0, 1'b0);
        i_wait[2] = 1'b1;
        wait_done();
        i_wait[2] = 1'b0;
        chk("overrun set", 64'(o_overrun), 64'd1);
        check_sets("overrun");

        // Reset mid-wait aborts silently.
        drive(3'd2, 8'd1, 32'd0, 32'd0, 2'd0, 0, 1'b0);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        exp_err = 0;
        for (int k = 0; k < 5; k++) exp_set[k] = 32'd0;
        chk("abort busy", 64'(o_busy), 64'd0);
        chk("abort ack", 64'(o_cmd_ack), 64'd0);
        chk("abort status", 64'(o_cmd_status), 64'd0);
        chk("abort err", 64'(o_err_cnt), 64'd0);
        chk("abort overrun", 64'(o_overrun), 64'd0);
        check_sets("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        drive(3'd1, 8'd3, 32'h77, 32'd0, 2'd0, 1, 1'b1);
        exp_set[3] = 32'h77;
        wait_done();
        check_sets("post rst");
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
